// File: rtl/move_scheduler_pkg.sv
// Shared definitions for the move scheduler: move codes, FSM encoding, level width and
// the gravity period helper.
package move_scheduler_pkg;

    localparam int unsigned LEVEL_W = 3;

    localparam logic [1:0] CODE_DOWN  = 2'b00;
    localparam logic [1:0] CODE_LEFT  = 2'b01;
    localparam logic [1:0] CODE_RIGHT = 2'b10;
    localparam logic [1:0] CODE_ROT   = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResolve
    } state_t;

    typedef enum logic [1:0] {
        ResApply,
        ResRevert,
        ResSpawn
    } result_t;

    // Gravity period for a level: base minus level*step, never below one step.
    function automatic logic [23:0] gravity_period(input logic [LEVEL_W-1:0] lvl,
                                                   input logic [23:0]        base,
                                                   input logic [23:0]        step);
        logic [27:0] red;
        red = 28'(lvl) * 28'(step);
        if ({4'b0, base} < red + {4'b0, step}) begin
            return step;
        end
        return base - red[23:0];
    endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Playfield link: request/proposal from the scheduler, responses, score feed and outcome pulses.
interface move_scheduler_if;
    logic        movement_request;
    logic        movement_intent;
    logic [1:0]  propose_code;
    logic        propose_valid;
    logic        move_apply;
    logic        move_revert;
    logic        piece_spawn;
    logic        movement_commit;
    logic        movement_declined;
    logic        movement_steal;
    logic [15:0] scorewire;

    modport master (
        output movement_request, movement_intent, propose_code, propose_valid,
        output move_apply, move_revert, piece_spawn,
        input  movement_commit, movement_declined, movement_steal, scorewire
    );

    modport slave (
        input  movement_request, movement_intent, propose_code, propose_valid,
        input  move_apply, move_revert, piece_spawn,
        output movement_commit, movement_declined, movement_steal, scorewire
    );
endinterface

// File: rtl/move_scheduler_gravity_timer.sv
// Gravity timer: free-running counter against a level-dependent period, emitting a one-cycle
// tick. With SOFT_DROP_EN defined, holding btn_down adds a tick every GRAVITY_STEP/4 cycles;
// without it btn_down is ignored and the soft-drop counter does not exist.
module move_scheduler_gravity_timer
    import move_scheduler_pkg::*;
#(
    parameter logic [23:0] GRAVITY_BASE = 24'd6000000,
    parameter logic [23:0] GRAVITY_STEP = 24'd700000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    input  logic               clear,
    input  logic               btn_down,
    output logic               tick
);
    logic [23:0] period;
    logic [23:0] cnt_q, cnt_d;
    logic        grav_tick;

    assign period = gravity_period(level, GRAVITY_BASE, GRAVITY_STEP);
    // >= so a level-up that shrinks the period below the running count fires straight away.
    assign grav_tick = (cnt_q >= period - 24'd1);

    // Count up, reload on expiry or when the playfield steals the piece.
    always_comb begin
        cnt_d = cnt_q + 24'd1;
        if (clear || grav_tick) begin
            cnt_d = '0;
        end
    end

    // Gravity counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef SOFT_DROP_EN
    localparam logic [23:0] SoftPeriod = ((GRAVITY_STEP >> 2) == 24'd0) ? 24'd1 :
                                         (GRAVITY_STEP >> 2);
    logic [23:0] soft_q, soft_d;
    logic        soft_tick;

    assign soft_tick = btn_down && (soft_q >= SoftPeriod - 24'd1);

    // Soft-drop counter runs only while the button is held.
    always_comb begin
        soft_d = soft_q + 24'd1;
        if (!btn_down || soft_tick || clear) begin
            soft_d = '0;
        end
    end

    // Soft-drop counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            soft_q <= '0;
        end else begin
            soft_q <= soft_d;
        end
    end

    assign tick = (grav_tick || soft_tick) && !clear;
`else
    logic unused_btn_down;
    assign unused_btn_down = btn_down;
    assign tick = grav_tick && !clear;
`endif

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: arbitrates gravity and player move requests towards the playfield, waits
// for its response and turns it into apply / revert / spawn pulses; tracks score and level.
// Build option SOFT_DROP_EN enables btn_down soft drop inside the gravity timer.
module move_scheduler
    import move_scheduler_pkg::*;
#(
    parameter logic [23:0] GRAVITY_BASE = 24'd6000000,
    parameter logic [23:0] GRAVITY_STEP = 24'd700000,
    parameter logic [15:0] LEVEL_POINTS = 16'd400,
    parameter logic [5:0]  RESP_TIMEOUT = 6'd31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               core_busy,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_rot,
    input  logic               btn_down,
    move_scheduler_if.master   pf,
    output logic [LEVEL_W-1:0] level,
    output logic               timeout_err
);
    state_t             state_q, state_d;
    result_t            res_q, res_d;
    logic [1:0]         code_q, code_d;
    logic               intent_q, intent_d;
    logic [5:0]         wait_q, wait_d;
    logic               timeout_q, timeout_d;
    logic               grav_pend_q, grav_pend_d;
    logic               rot_pend_q, rot_pend_d;
    logic               left_pend_q, left_pend_d;
    logic               right_pend_q, right_pend_d;
    logic [2:0]         btn_prev_q;
    logic               rot_rise, left_rise, right_rise;
    logic [16:0]        accum_q, accum_d, score_sum, level_raw;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               grav_tick, steal_clear;

    assign steal_clear = (state_q == StResolve) && (res_q == ResSpawn);

    move_scheduler_gravity_timer #(
        .GRAVITY_BASE (GRAVITY_BASE),
        .GRAVITY_STEP (GRAVITY_STEP)
    ) u_gravity_timer (
        .clk      (clk),
        .reset    (reset),
        .level    (level_q),
        .clear    (steal_clear),
        .btn_down (btn_down),
        .tick     (grav_tick)
    );

    assign rot_rise   = btn_rot   & ~btn_prev_q[2];
    assign left_rise  = btn_left  & ~btn_prev_q[1];
    assign right_rise = btn_right & ~btn_prev_q[0];

    // Request arbitration, response wait and resolution; pending latches merge repeat events.
    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        code_d       = code_q;
        intent_d     = intent_q;
        wait_d       = wait_q;
        timeout_d    = timeout_q;
        grav_pend_d  = grav_pend_q  | grav_tick;
        rot_pend_d   = rot_pend_q   | rot_rise;
        left_pend_d  = left_pend_q  | left_rise;
        right_pend_d = right_pend_q | right_rise;
        unique case (state_q)
            StIdle: begin
                if (!core_busy && (grav_pend_q || rot_pend_q || left_pend_q || right_pend_q)) begin
                    state_d  = StIssue;
                    wait_d   = '0;
                    intent_d = 1'b1;
                    if (grav_pend_q) begin
                        code_d      = CODE_DOWN;
                        intent_d    = 1'b0;
                        grav_pend_d = grav_tick;
                    end else if (rot_pend_q) begin
                        code_d     = CODE_ROT;
                        rot_pend_d = rot_rise;
                    end else if (left_pend_q) begin
                        code_d      = CODE_LEFT;
                        left_pend_d = left_rise;
                    end else begin
                        code_d       = CODE_RIGHT;
                        right_pend_d = right_rise;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (pf.movement_steal) begin
                    res_d   = ResSpawn;
                    state_d = StResolve;
                end else if (pf.movement_declined) begin
                    res_d   = ResRevert;
                    state_d = StResolve;
                end else if (pf.movement_commit) begin
                    res_d   = ResApply;
                    state_d = StResolve;
                end else begin
                    wait_d = wait_q + 6'd1;
                    if (wait_d >= RESP_TIMEOUT) begin
                        res_d     = ResRevert;
                        timeout_d = 1'b1;
                        state_d   = StResolve;
                    end
                end
            end
            StResolve: begin
                state_d = StIdle;
                // A new piece makes every queued move stale.
                if (res_q == ResSpawn) begin
                    grav_pend_d  = 1'b0;
                    rot_pend_d   = 1'b0;
                    left_pend_d  = 1'b0;
                    right_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Saturating score accumulator; level follows one cycle after a nonzero increment.
    assign score_sum = accum_q + {1'b0, pf.scorewire};
    always_comb begin
        accum_d   = (score_sum > 17'h0FFFF) ? 17'h0FFFF : score_sum;
        level_raw = accum_d / {1'b0, LEVEL_POINTS};
        level_d   = level_q;
        if (pf.scorewire != 16'd0) begin
            level_d = (level_raw > 17'd7) ? 3'd7 : level_raw[2:0];
        end
    end

    // State, pending latches, score and sticky error registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            res_q        <= ResApply;
            code_q       <= CODE_DOWN;
            intent_q     <= 1'b0;
            wait_q       <= '0;
            timeout_q    <= 1'b0;
            grav_pend_q  <= 1'b0;
            rot_pend_q   <= 1'b0;
            left_pend_q  <= 1'b0;
            right_pend_q <= 1'b0;
            btn_prev_q   <= '0;
            accum_q      <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            code_q       <= code_d;
            intent_q     <= intent_d;
            wait_q       <= wait_d;
            timeout_q    <= timeout_d;
            grav_pend_q  <= grav_pend_d;
            rot_pend_q   <= rot_pend_d;
            left_pend_q  <= left_pend_d;
            right_pend_q <= right_pend_d;
            btn_prev_q   <= {btn_rot, btn_left, btn_right};
            accum_q      <= accum_d;
            level_q      <= level_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        pf.movement_request = (state_q == StIssue);
        pf.propose_valid    = (state_q != StIdle);
        pf.propose_code     = pf.propose_valid ? code_q : CODE_DOWN;
        pf.movement_intent  = pf.propose_valid && intent_q;
        pf.move_apply       = (state_q == StResolve) && (res_q == ResApply);
        pf.move_revert      = (state_q == StResolve) && (res_q == ResRevert);
        pf.piece_spawn      = steal_clear;
        level               = level_q;
        timeout_err         = timeout_q;
    end

endmodule
